// File: rtl/shift_add_multiplier.sv
// shift_add_multiplier: sequential unsigned multiplier iterating one shared ripple-carry adder
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module ripple_carry_adder #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  logic [WIDTH:0] c;
  assign c[0] = cin;
  assign cout = c[WIDTH];
  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    full_adder u_fa (.a(a[i]), .b(b[i]), .cin(c[i]), .sum(sum[i]), .cout(c[i+1]));
  end
endmodule

module shift_add_multiplier #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);
  localparam int CW = $clog2(WIDTH) + 1;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] m, acc, q, addend, sum, next_acc, next_q;
  logic [CW-1:0] cnt;
  logic cout;
  assign addend = q[0] ? m : '0;
  ripple_carry_adder #(.WIDTH(WIDTH)) u_add (
    .a(acc), .b(addend), .cin(1'b0), .sum(sum), .cout(cout)
  );
  // The carry-out becomes the new MSB of the high half on every shift.
  assign next_acc = {cout, sum[WIDTH-1:1]};
  assign next_q   = {sum[0], q[WIDTH-1:1]};
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      ready   <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
      m       <= '0;
      acc     <= '0;
      q       <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          m     <= a;
          q     <= b;
          acc   <= '0;
          cnt   <= '0;
          state <= CALC;
          ready <= 1'b0;
          busy  <= 1'b1;
        end
        CALC: begin
          acc <= next_acc;
          q   <= next_q;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            product <= {next_acc, next_q};
            state   <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          ready <= 1'b1;
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end
endmodule
